// File: rtl/frac_ce_gen.sv
// N-channel NCO clock-enable generator; one-cycle ce pulses at refclk*inc/2^ACC_W per channel.
// Latency: an accepted write takes effect the next cycle; ce is registered off the accumulator carry.
// Backpressure: cfg_ready drops for SETTLE cycles after each accepted write, until locked returns.
module frac_ce_gen #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32,
    parameter int SETTLE   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_phase,
    input  logic                cfg_sync,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc [CHANNELS];
    logic [ACC_W-1:0]   inc [CHANNELS];
    logic [ACC_W:0]     sum [CHANNELS];
    logic [CHANNELS-1:0] ce_q;
    logic               ch_ok;
    logic               wr_en;

    // A full power-of-two channel count leaves no out-of-range index to reject.
    generate
        if (CHANNELS == (1 << CH_W)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = (32'(cfg_ch) < CHANNELS);
        end
    endgenerate

    assign wr_en = cfg_valid & cfg_ready & ch_ok;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // The load on the written channel overrides any carry it would have produced.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                inc[i] <= '0;
            end
            ce_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (cfg_ch == CH_W'(i))) begin
                    inc[i]  <= cfg_inc;
                    acc[i]  <= cfg_phase;
                    ce_q[i] <= 1'b0;
                end else if (wr_en && cfg_sync) begin
                    acc[i]  <= '0;
                    ce_q[i] <= 1'b0;
                end else begin
                    acc[i]  <= sum[i][ACC_W-1:0];
                    ce_q[i] <= sum[i][ACC_W];
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            UNLOCKED, LOCKED: begin
                if (wr_en) begin
                    state_d = SETTLING;
                    cnt_d   = CNT_W'(SETTLE - 1);
                end
            end
            SETTLING: begin
                if (cnt_q == '0) begin
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                cnt_d   = '0;
            end
        endcase
    end

    assign cfg_ready = (state_q != SETTLING);
    assign locked    = (state_q == LOCKED);
    assign ce        = ce_q;

endmodule

// File: tb/tb_frac_ce_gen.sv
// Directed bench for frac_ce_gen with a cycle-level reference model feeding a scoreboard.
// Three channels are instantiated so that an index past the last channel is encodable.
module tb_frac_ce_gen;

    localparam int CHANNELS = 3;
    localparam int ACC_W    = 32;
    localparam int SETTLE   = 16;
    localparam int CH_W     = 2;
    localparam logic [63:0] MOD = 64'd1 << ACC_W;

    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [ACC_W-1:0]    cfg_inc = '0;
    logic [ACC_W-1:0]    cfg_phase = '0;
    logic                cfg_sync = 1'b0;
    logic [CHANNELS-1:0] ce;
    logic                locked;

    int chk_n = 0;
    int err_n = 0;

    frac_ce_gen #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .SETTLE(SETTLE)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_sync  (cfg_sync),
        .ce        (ce),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: 64-bit modular accumulators and a count of edges left until lock.
    logic [63:0]         m_acc [CHANNELS];
    logic [63:0]         m_inc [CHANNELS];
    logic [63:0]         n_acc [CHANNELS];
    logic [63:0]         n_inc [CHANNELS];
    logic [CHANNELS-1:0] n_ce;
    int                  m_lock_in, n_lock_in;
    logic                m_settling = 1'b0, n_settling;
    logic                m_locked = 1'b0, n_locked;
    logic                m_live = 1'b0;
    logic [CHANNELS+1:0] sb_q [$];

    always_comb begin
        logic        take;
        logic [63:0] s;
        take       = cfg_valid && !m_settling && (int'(cfg_ch) < CHANNELS);
        n_ce       = '0;
        n_lock_in  = m_lock_in;
        n_settling = m_settling;
        n_locked   = m_locked;
        s          = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s        = m_acc[i] + m_inc[i];
            n_ce[i]  = (s >= MOD);
            n_acc[i] = s % MOD;
            n_inc[i] = m_inc[i];
            if (take && int'(cfg_ch) == i) begin
                n_inc[i] = 64'(cfg_inc);
                n_acc[i] = 64'(cfg_phase);
                n_ce[i]  = 1'b0;
            end else if (take && cfg_sync) begin
                n_acc[i] = '0;
                n_ce[i]  = 1'b0;
            end
        end
        if (take) begin
            n_settling = 1'b1;
            n_locked   = 1'b0;
            n_lock_in  = SETTLE;
        end else if (m_settling) begin
            n_lock_in = m_lock_in - 1;
            if (n_lock_in == 0) begin
                n_settling = 1'b0;
                n_locked   = 1'b1;
            end
        end
    end

    always @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_acc[i] <= '0;
                m_inc[i] <= '0;
            end
            m_lock_in  <= 0;
            m_settling <= 1'b0;
            m_locked   <= 1'b0;
            m_live     <= 1'b1;
            sb_q.push_back({{CHANNELS{1'b0}}, 1'b0, 1'b1});
        end else if (m_live) begin
            m_acc      <= n_acc;
            m_inc      <= n_inc;
            m_lock_in  <= n_lock_in;
            m_settling <= n_settling;
            m_locked   <= n_locked;
            sb_q.push_back({n_ce, n_locked, ~n_settling});
        end
    end

    always @(negedge refclk) begin
        logic [CHANNELS+1:0] exp_v;
        if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            chk_n++;
            assert ({ce, locked, cfg_ready} === exp_v) else begin
                err_n++;
                $error("FAIL sb_ce_locked_ready observed %b expected %b", {ce, locked, cfg_ready}, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        chk_n++;
        assert (observed === expected) else begin
            err_n++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Presents a write and returns at the negedge just after the accepting edge.
    task automatic do_write(input int ch, input logic [31:0] inc_v, input logic [31:0] ph_v,
                            input logic sync_v);
        int w;
        cfg_ch    = ch[CH_W-1:0];
        cfg_inc   = inc_v;
        cfg_phase = ph_v;
        cfg_sync  = sync_v;
        cfg_valid = 1'b1;
        w = 0;
        while (!cfg_ready && w < 64) begin
            @(negedge refclk);
            w++;
        end
        check("wr_ready_wait", int'(cfg_ready), 1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        cfg_sync  = 1'b0;
    endtask

    initial begin
        int cnt, first, last, bad, n, diff;

        // Reset and idle
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        check("reset_outputs", int'({ce, locked, cfg_ready}), 1);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (ce != '0 || locked || !cfg_ready) cnt++;
        end
        check("idle_quiet", cnt, 0);

        // Quarter-rate channel 0: first pulse follows the 4th edge after acceptance
        do_write(0, 32'h4000_0000, 32'h0, 1'b0);
        check("locked_low_after_write", int'(locked), 0);
        cnt = 0; first = -1; last = -1;
        for (int k = 1; k <= 400; k++) begin
            tick(1);
            if (ce[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (locked && last < 0) last = k;
        end
        check("ch0_first_pulse", first, 4);
        check("ch0_pulse_count", cnt, 100);
        check("ch0_lock_edge", last, SETTLE);

        // One-third rate on channel 1
        do_write(1, 32'h5555_5555, 32'h0, 1'b0);
        cnt = 0; last = 0; bad = 0;
        for (int k = 1; k <= 3000; k++) begin
            tick(1);
            if (ce[1]) begin
                if (cnt > 0 && (k - last < 3 || k - last > 4)) bad++;
                cnt++;
                last = k;
            end
        end
        check("ch1_count_in_range", int'(cnt == 999 || cnt == 1000), 1);
        check("ch1_spacing", bad, 0);

        // cfg_valid held across the settle window
        cfg_ch = 2'd0; cfg_inc = 32'h4000_0000; cfg_phase = '0; cfg_sync = 1'b0;
        cfg_valid = 1'b1;
        tick(1);
        n = 1;
        cfg_ch = 2'd1; cfg_inc = 32'h5555_5555;
        while (!cfg_ready && n < 64) begin
            tick(1);
            n++;
        end
        check("ready_low_cycles", n - 1, SETTLE);
        tick(1);
        cfg_valid = 1'b0;
        n++;
        while (!locked && n < 100) begin
            tick(1);
            n++;
        end
        check("second_lock_cycle", n, 2 * SETTLE + 2);

        // Phase-offset channels realigned by a sync write
        do_write(1, 32'h1000_0000, 32'h8000_0000, 1'b0);
        do_write(0, 32'h1000_0000, 32'h1234_5678, 1'b0);
        diff = 0;
        for (int k = 0; k < 64; k++) begin
            tick(1);
            if (ce[0] != ce[1]) diff++;
        end
        check("offset_before_sync", int'(diff > 0), 1);
        do_write(0, 32'h1000_0000, 32'h0, 1'b1);
        diff = 0; cnt = 0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (ce[0] != ce[1]) diff++;
            if (ce[0]) cnt++;
        end
        check("sync_coincide", diff, 0);
        check("sync_pulses", cnt, 12);

        // Reset in the middle of settling
        do_write(1, 32'h2000_0000, 32'h0, 1'b0);
        tick(7);
        check("settling_before_rst", int'(cfg_ready), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_settle_outputs", int'({ce, locked, cfg_ready}), 1);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (ce != '0 || locked) cnt++;
        end
        check("inc_cleared", cnt, 0);

        // Write to a channel index that does not exist
        do_write(0, 32'h4000_0000, 32'h0, 1'b0);
        tick(20);
        check("locked_before_bad_ch", int'(locked), 1);
        do_write(3, 32'h1111_1111, 32'h0, 1'b1);
        check("bad_ch_ready", int'(cfg_ready), 1);
        cnt = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (ce[0]) cnt++;
            if (!locked || ce[2:1] != 2'b00) bad++;
        end
        check("bad_ch_ce0_count", cnt, 10);
        check("bad_ch_no_effect", bad, 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end

endmodule
